// File: rtl/pendulum_spi_pkg.sv
// Shared definitions for the pendulum SPI link: frame size, responder states
// and command-frame field positions.
package pendulum_spi_pkg;

   localparam int FRAME_BITS_DEFAULT = 136;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      ACTIVE
   } spi_resp_state_t;

   localparam int SPEED_LSB   = 0;
   localparam int SPEED_MSB   = 14;
   localparam int ENABLE_BIT  = 15;
   localparam int RST_ENC_LSB = 116;
   localparam int RST_ENC_MSB = 117;

   function automatic logic [SPEED_MSB-SPEED_LSB:0] cmd_speed(
      input logic [FRAME_BITS_DEFAULT-1:0] frame
   );
      return frame[SPEED_MSB:SPEED_LSB];
   endfunction

endpackage

// File: rtl/spi_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with rise/fall detect
// against the previous synchronized sample. STAGES must be at least 2.
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync_reg [STAGES];
   logic prev_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) sync_reg[gi] <= RST_VAL;
               else          sync_reg[gi] <= din;
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) sync_reg[gi] <= RST_VAL;
               else          sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_reg <= RST_VAL;
      else          prev_reg <= level;
   end

   assign level = sync_reg[STAGES-1];
   assign rise  = level & ~prev_reg;
   assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: shifts in a FRAME_BITS command frame on mosi and shifts
// the tx_data word captured at frame start back out on miso.
module spi_responder
   import pendulum_spi_pkg::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  ss,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [FRAME_BITS-1:0] tx_data,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic ss_rise, ss_fall, ss_level;
   logic mosi_sync_reg [SYNC_STAGES];

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sclk),
      .level   (sclk_level_unused),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (ss),
      .level   (ss_level),
      .rise    (ss_rise),
      .fall    (ss_fall)
   );

   // Same depth as the sclk chain so mosi is sampled aligned with its clock edge.
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) mosi_sync_reg[gi] <= 1'b0;
               else          mosi_sync_reg[gi] <= mosi;
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) mosi_sync_reg[gi] <= 1'b0;
               else          mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
            end
         end
      end
   endgenerate

   spi_resp_state_t       state_reg;
   logic [FRAME_BITS-1:0] tx_shift_reg;
   logic [FRAME_BITS-1:0] rx_shift_reg;
   logic [FRAME_BITS-1:0] rx_data_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic                  miso_reg;
   logic                  miso_oe_reg;
   logic                  rx_valid_reg;
   logic                  frame_error_reg;
   logic [SYNC_STAGES:0]  startup_reg;

   // The ss chain resets high, so an ss pin held low through reset shows up as
   // a falling edge while startup_reg is still filling; that case arms instead.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         tx_shift_reg    <= '0;
         rx_shift_reg    <= '0;
         rx_data_reg     <= '0;
         bit_cnt_reg     <= '0;
         miso_reg        <= 1'b0;
         miso_oe_reg     <= 1'b0;
         rx_valid_reg    <= 1'b0;
         frame_error_reg <= 1'b0;
         startup_reg     <= '0;
      end else begin
         rx_valid_reg    <= 1'b0;
         frame_error_reg <= 1'b0;
         startup_reg     <= {startup_reg[SYNC_STAGES-1:0], 1'b1};
         case (state_reg)
            IDLE: begin
               if (ss_fall) begin
                  if (!startup_reg[SYNC_STAGES]) begin
                     state_reg <= ARMED;
                  end else begin
                     tx_shift_reg <= tx_data;
                     miso_reg     <= tx_data[FRAME_BITS-1];
                     miso_oe_reg  <= 1'b1;
                     bit_cnt_reg  <= '0;
                     state_reg    <= ACTIVE;
                  end
               end
            end
            ARMED: begin
               if (ss_level) state_reg <= IDLE;
            end
            ACTIVE: begin
               if (ss_rise) begin
                  if (bit_cnt_reg == CNT_FULL) begin
                     rx_data_reg  <= rx_shift_reg;
                     rx_valid_reg <= 1'b1;
                  end else begin
                     frame_error_reg <= 1'b1;
                  end
                  miso_oe_reg <= 1'b0;
                  miso_reg    <= 1'b0;
                  state_reg   <= IDLE;
               end else begin
                  if (sclk_rise) begin
                     rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], mosi_sync_reg[SYNC_STAGES-1]};
                     if (bit_cnt_reg != CNT_MAX) bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
                  if (sclk_fall) begin
                     tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                     miso_reg     <= tx_shift_reg[FRAME_BITS-2];
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign miso        = miso_reg;
   assign miso_oe     = miso_oe_reg;
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign frame_error = frame_error_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: nominal, short, long, back-to-back and
// reset-mid-frame cases with hand-computed expected words.
module tb_spi_responder;
   import pendulum_spi_pkg::*;

   logic         clk;
   logic         reset_n;
   logic         sclk;
   logic         mosi;
   logic         ss;
   logic         miso;
   logic         miso_oe;
   logic [135:0] tx_data;
   logic [135:0] rx_data;
   logic         rx_valid;
   logic         frame_error;
   logic         busy;

   spi_responder #(.FRAME_BITS(136), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sclk        (sclk),
      .mosi        (mosi),
      .ss          (ss),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int bad_cnt   = 0;
   logic armed_window;
   logic [135:0] rx_q[$];

   always @(posedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         rx_q.push_back(rx_data);
      end
      if (frame_error) err_cnt++;
      if (armed_window && (miso_oe || rx_valid || frame_error)) bad_cnt++;
   end

   task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One frame with sclk = clk/10; miso sampled just before each rising sclk.
   task automatic send_frame(input int n, input logic [135:0] cmd, input int chg_at,
                             input logic [135:0] chg_val, input int rst_at,
                             output logic [135:0] capt, output logic [3:0] extra);
      capt  = '0;
      extra = '0;
      ss = 1'b0;
      #50;
      for (int i = 0; i < n; i++) begin
         mosi = (i < 136) ? cmd[135-i] : 1'b0;
         if (i == chg_at) tx_data = chg_val;
         if (i == rst_at) begin
            reset_n = 1'b0;
            armed_window = 1'b1;
            #1;
            check("rst_miso_oe", 136'(miso_oe), 136'(0));
            check("rst_busy", 136'(busy), 136'(0));
            #19;
            reset_n = 1'b1;
         end
         #50;
         if (i < 136) capt[135-i] = miso;
         else if (i < 140) extra[139-i] = miso;
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
      #50;
      if (rst_at >= 0) check("armed_busy", 136'(busy), 136'(1));
      ss = 1'b1;
   endtask

   initial begin
      logic [135:0] t1, t2, t3, t4, t5;
      logic [135:0] cmd1, cmd2, cmd3, cmda, cmdb, cmdc, cmdd;
      logic [135:0] capt, capt_b;
      logic [3:0]   extra;
      int vb, eb, qb;

      t1   = 136'h12_3456_789A_BCDE_F012_3456_789A_07FF_0400;
      t2   = 136'hA5_5A5A_C3C3_0F0F_F0F0_1234_5678_9ABC_DEFF;
      t3   = 136'h80_0000_0000_0000_0000_0000_0000_0000_0001;
      t4   = 136'h7F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
      t5   = 136'h3C_1111_2222_3333_4444_5555_6666_7777_8889;
      cmd1 = 136'hFE_DCBA_9876_5432_10FE_DCBA_9876_0000_8123;
      cmd2 = 136'h11_2233_4455_6677_8899_AABB_CCDD_EEFF_0011;
      cmd3 = 136'h22_2222_2222_2222_2222_2222_2222_2222_2222;
      cmda = 136'h01_0203_0405_0607_0809_0A0B_0C0D_0E0F_1011;
      cmdb = 136'hF0_E0D0_C0B0_A090_8070_6050_4030_2010_0F0E;
      cmdc = 136'h55_5555_5555_5555_5555_5555_5555_5555_5555;
      cmdd = 136'h9C_30F0_0000_0000_0000_0000_0000_0000_FFFF;

      reset_n = 1'b0;
      ss = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      tx_data = t1;
      armed_window = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_miso", 136'(miso), 136'(0));
      check("reset_miso_oe", 136'(miso_oe), 136'(0));
      check("reset_rx_data", rx_data, 136'(0));
      check("reset_rx_valid", 136'(rx_valid), 136'(0));
      check("reset_frame_error", 136'(frame_error), 136'(0));
      check("reset_busy", 136'(busy), 136'(0));
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", 136'(busy), 136'(0));

      // Nominal frame: speed 0x0123, enable set
      vb = valid_cnt; eb = err_cnt;
      send_frame(136, cmd1, -1, '0, -1, capt, extra);
      repeat (10) @(negedge clk);
      check("nom_valid_pulses", 136'(valid_cnt - vb), 136'(1));
      check("nom_err_pulses", 136'(err_cnt - eb), 136'(0));
      check("nom_rx_low16", 136'(rx_data[15:0]), 136'(16'h8123));
      check("nom_speed", 136'(cmd_speed(rx_data)), 136'(15'h0123));
      check("nom_enable", 136'(rx_data[ENABLE_BIT]), 136'(1));
      check("nom_rx_data", rx_data, cmd1);
      check("nom_miso_word", capt, t1);
      check("nom_miso_oe_after", 136'(miso_oe), 136'(0));
      check("nom_busy_after", 136'(busy), 136'(0));

      // Short frame: 135 clocks
      tx_data = t2;
      vb = valid_cnt; eb = err_cnt;
      send_frame(135, cmd2, -1, '0, -1, capt, extra);
      repeat (10) @(negedge clk);
      check("short_err_pulses", 136'(err_cnt - eb), 136'(1));
      check("short_valid_pulses", 136'(valid_cnt - vb), 136'(0));
      check("short_rx_kept", rx_data, cmd1);
      check("short_miso_135", capt >> 1, t2 >> 1);

      // Long frame: 140 clocks
      vb = valid_cnt; eb = err_cnt;
      send_frame(140, cmd3, -1, '0, -1, capt, extra);
      repeat (10) @(negedge clk);
      check("long_err_pulses", 136'(err_cnt - eb), 136'(1));
      check("long_valid_pulses", 136'(valid_cnt - vb), 136'(0));
      check("long_miso_word", capt, t2);
      check("long_miso_tail", 136'(extra), 136'(0));
      check("long_rx_kept", rx_data, cmd1);

      // Back-to-back with minimum ss-high gap; tx_data changes mid-first-frame
      tx_data = t3;
      vb = valid_cnt;
      qb = rx_q.size();
      send_frame(136, cmda, 70, t4, -1, capt, extra);
      #40;
      send_frame(136, cmdb, -1, '0, -1, capt_b, extra);
      repeat (10) @(negedge clk);
      check("b2b_valid_pulses", 136'(valid_cnt - vb), 136'(2));
      check("b2b_first_rx", (rx_q.size() > qb) ? rx_q[qb] : '0, cmda);
      check("b2b_second_rx", (rx_q.size() > qb + 1) ? rx_q[qb+1] : '0, cmdb);
      check("b2b_first_miso", capt, t3);
      check("b2b_second_miso", capt_b, t4);

      // Reset at bit 60, released with ss low
      vb = valid_cnt; eb = err_cnt;
      send_frame(136, cmdc, -1, '0, 60, capt, extra);
      repeat (10) @(negedge clk);
      check("rstmid_quiet", 136'(bad_cnt), 136'(0));
      check("rstmid_valid_pulses", 136'(valid_cnt - vb), 136'(0));
      check("rstmid_err_pulses", 136'(err_cnt - eb), 136'(0));
      check("rstmid_busy_after", 136'(busy), 136'(0));
      check("rstmid_rx_cleared", rx_data, 136'(0));
      armed_window = 1'b0;

      tx_data = t5;
      vb = valid_cnt; eb = err_cnt;
      send_frame(136, cmdd, -1, '0, -1, capt, extra);
      repeat (10) @(negedge clk);
      check("post_valid_pulses", 136'(valid_cnt - vb), 136'(1));
      check("post_err_pulses", 136'(err_cnt - eb), 136'(0));
      check("post_rx_data", rx_data, cmdd);
      check("post_rst_enc", 136'(rx_data[RST_ENC_MSB:RST_ENC_LSB]), 136'(2'b11));
      check("post_miso_word", capt, t5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
# spi_responder

Responder (slave) end of the 136-bit pendulum SPI link, clocked in the system clock domain. It emulates the encoder/motor board for hardware-in-the-loop benches and for a second FPGA acting as the plant. The controller's SPI initiator drives `sclk`, `mosi` and `ss`. This block shifts in each command frame, presents it as a parallel word with a one-cycle strobe, and shifts a parallel status word (encoder counts) back out on `miso`.

## Interface
- `FRAME_BITS`, 136: bits per frame; a frame is complete only at exactly this count.
- `SYNC_STAGES`, 2: flip-flop stages on each of `sclk`, `mosi`, `ss` (minimum 2).
- `clk` in 1: system clock; every flop is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from the initiator. Asynchronous to `clk`.
- `mosi` in 1: command data from the initiator, MSB first.
- `ss` in 1: active-low frame select.
- `miso` out 1: response data, MSB first. Reset value 0.
- `miso_oe` out 1: high while a frame is active; the top level tri-states `miso` when this is low. Reset value 0.
- `tx_data` in FRAME_BITS: response word, captured when the frame starts.
- `rx_data` out FRAME_BITS: last complete command frame. Reset value 0.
- `rx_valid` out 1: one-cycle strobe when `rx_data` updates. Reset value 0.
- `frame_error` out 1: one-cycle strobe when a frame ends with a wrong bit count. Reset value 0.
- `busy` out 1: high whenever the state is not IDLE. Reset value 0.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0).
  - `mosi` is sampled on each synchronized `sclk` rising edge.
  - `miso` is updated on each synchronized `sclk` falling edge.
- Synchronizer reset values: `ss` chain resets to 1; `sclk` and `mosi` chains reset to 0.
- State machine has three states: IDLE, ARMED, ACTIVE.
- **IDLE**
  - On a synchronized `ss` falling edge: load the tx shift register from `tx_data`, drive `miso` = `tx_data[FRAME_BITS-1]`, set `miso_oe`=1, clear `bit_cnt`, go to ACTIVE.
  - If `ss` is already low when reset is released: go to ARMED instead.
- **ARMED**
  - Ignore all traffic; go to IDLE when synchronized `ss` is high.
- **ACTIVE**
  - On an `sclk` rising edge: shift `mosi` into the rx shift register (LSB end), then `bit_cnt`++. `bit_cnt` saturates at FRAME_BITS+1.
  - On an `sclk` falling edge: shift the tx register left and drive its MSB onto `miso`. Vacated positions fill with 0, so `miso`=0 after bit 136.
  - On a synchronized `ss` rising edge:
    - If `bit_cnt`==FRAME_BITS: `rx_data` <= rx shift register and pulse `rx_valid`.
    - Otherwise: pulse `frame_error` and leave `rx_data` unchanged.
    - In both cases: `miso_oe`=0, `miso`=0, go to IDLE.
- If an `sclk` edge and an `ss` rise are detected in the same cycle, the `ss` rise wins and the edge is discarded.
- `tx_data` changes during a frame have no effect on that frame.
- Reset asserted mid-frame forces every output to its reset value immediately and discards the partial frame with no strobe.

## Timing
- Pin-to-detection latency is SYNC_STAGES+1 `clk` cycles (synchronizer plus edge-detect register).
- `rx_valid` and `frame_error` are asserted in the cycle after the `ss` rising edge is detected, for exactly one cycle. `rx_data` is stable from that cycle onward.
- `clk` must be at least 8× `sclk`, and `ss` must stay high for at least 4 `clk` cycles between frames. Frames spaced at exactly the minimum must all be accepted.
- `miso` changes at most SYNC_STAGES+2 `clk` cycles after the `sclk` falling edge at the pin. This is within the half-period of the initiator's sample edge under the 8× rule.

## Structure
- Package `pendulum_spi_pkg` holds:
  - `FRAME_BITS_DEFAULT` (136)
  - the state enum `spi_resp_state_t` {IDLE, ARMED, ACTIVE}
  - field offsets of the command frame: speed [14:0], enable bit 15, reset-encoder bits [117:116]
- Sub-module `sync_edge`: a SYNC_STAGES synchronizer plus rise/fall detect with a parameterized reset value. It is instantiated for `sclk` and `ss`; `mosi` uses the synchronizer only.

## Test plan
- **Nominal frame.** Reset, `tx_data`=136'h…_07FF_0400. Send a 136-bit frame with `sclk` = `clk`/10 carrying speed=15'h0123 and enable=1.
  - `rx_valid` pulses once; `rx_data[15:0]`=16'h8123.
  - Captured `miso` equals `tx_data` bit for bit.
  - `miso_oe` is low afterwards.
- **Short frame.** 135 clocks then `ss` rises → `frame_error` pulses once, `rx_valid` stays 0, `rx_data` keeps the previous value.
- **Long frame.** 140 clocks → `frame_error` pulses; `miso`=0 for clocks 137–140.
- **Back-to-back frames.** Two frames with `ss` high for 4 `clk` cycles between them, second `tx_data` changed mid-first-frame.
  - Two `rx_valid` pulses.
  - The first response is unaffected by the change; the second uses the new word.
- **Reset mid-frame.** Assert `reset_n` low at bit 60, release with `ss` still low, finish clocking, raise `ss`.
  - State is ARMED, with no strobes and `miso_oe`=0 throughout.
  - The next full frame is accepted normally.
